// File: rtl/master_frame_sender_if.sv
// Frame-sender bus: host request side plus the byte-level handshake to an SPI master.
// The master modport is the frame sender; slave is the host/SPI side.
interface master_frame_sender_if;
    logic [13:0] data_in;
    logic        send;
    logic        spi_ready;
    logic        spi_done;
    logic        spi_start;
    logic [7:0]  tx_data;
    logic        ssn;
    logic        busy;

    modport master (
        input  data_in,
        input  send,
        input  spi_ready,
        input  spi_done,
        output spi_start,
        output tx_data,
        output ssn,
        output busy
    );

    modport slave (
        output data_in,
        output send,
        output spi_ready,
        output spi_done,
        input  spi_start,
        input  tx_data,
        input  ssn,
        input  busy
    );
endinterface

// File: rtl/master_frame_sender.sv
// Sends a 0-9999 value as two SPI bytes {v/100, v%100} inside one ssn-low frame.
// The split is done by repeated subtraction, one step per cycle.
module master_frame_sender (
    input  logic                  clk,
    input  logic                  reset,
    master_frame_sender_if.master io_bus
);
    typedef enum logic [2:0] {
        StIdle,
        StSplit,
        StCsSetup,
        StSendHi,
        StWaitHi,
        StSendLo,
        StWaitLo,
        StCsHold
    } state_t;

    state_t      r_state;
    logic [6:0]  r_q;
    logic [13:0] r_r;
    logic        r_pend;
    logic [13:0] r_pend_val;
    logic        r_done_d1;
    logic        r_done_d2;
    logic        r_spi_start;
    logic [7:0]  r_tx_data;
    logic        r_ssn;

    logic [13:0] w_sat_in;
    logic        w_done_rise;

    assign w_sat_in    = (io_bus.data_in > 14'd9999) ? 14'd9999 : io_bus.data_in;
    assign w_done_rise = r_done_d1 & ~r_done_d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_q         <= 7'd0;
            r_r         <= 14'd0;
            r_pend      <= 1'b0;
            r_pend_val  <= 14'd0;
            r_done_d1   <= 1'b0;
            r_done_d2   <= 1'b0;
            r_spi_start <= 1'b0;
            r_tx_data   <= 8'h00;
            r_ssn       <= 1'b1;
        end else begin
            r_done_d1   <= io_bus.spi_done;
            r_done_d2   <= r_done_d1;
            r_spi_start <= 1'b0;

            // Requests arriving mid-frame collapse into one pending slot, latest wins.
            if (io_bus.send && (r_state != StIdle)) begin
                r_pend     <= 1'b1;
                r_pend_val <= w_sat_in;
            end

            unique case (r_state)
                StIdle: begin
                    if (r_pend) begin
                        r_q        <= 7'd0;
                        r_r        <= r_pend_val;
                        r_state    <= StSplit;
                        r_pend     <= io_bus.send;
                        if (io_bus.send) begin
                            r_pend_val <= w_sat_in;
                        end
                    end else if (io_bus.send) begin
                        r_q     <= 7'd0;
                        r_r     <= w_sat_in;
                        r_state <= StSplit;
                    end
                end
                StSplit: begin
                    if (r_r >= 14'd100) begin
                        r_r <= r_r - 14'd100;
                        r_q <= r_q + 7'd1;
                    end else begin
                        r_ssn   <= 1'b0;
                        r_state <= StCsSetup;
                    end
                end
                StCsSetup: begin
                    r_tx_data <= {1'b0, r_q};
                    r_state   <= StSendHi;
                end
                StSendHi: begin
                    if (io_bus.spi_ready) begin
                        r_spi_start <= 1'b1;
                        r_state     <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (w_done_rise) begin
                        r_tx_data <= {1'b0, r_r[6:0]};
                        r_state   <= StSendLo;
                    end
                end
                StSendLo: begin
                    if (io_bus.spi_ready) begin
                        r_spi_start <= 1'b1;
                        r_state     <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (w_done_rise) begin
                        r_state <= StCsHold;
                    end
                end
                StCsHold: begin
                    r_ssn   <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.spi_start = r_spi_start;
    assign io_bus.tx_data   = r_tx_data;
    assign io_bus.ssn       = r_ssn;
    assign io_bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_master_frame_sender.sv
// Scoreboard bench for master_frame_sender: expected bytes and split lengths are queued
// at send time and consumed by an SPI responder and an ssn monitor.
`timescale 1ns/1ps
module tb_master_frame_sender;
    logic clk;
    logic reset;

    master_frame_sender_if bus ();

    master_frame_sender u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];
    int         split_q[$];
    int         n_start;
    int         n_frames;
    int         done_delay;
    int         done_len;
    int         flush_req;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: saturate, split by 100, SPLIT lasts quotient+1 cycles.
    task automatic do_send(input int v, input bit replace);
        int s;
        s = (v > 9999) ? 9999 : v;
        if (replace) begin
            void'(exp_q.pop_back());
            void'(exp_q.pop_back());
            void'(split_q.pop_back());
        end
        exp_q.push_back(8'(s / 100));
        exp_q.push_back(8'(s % 100));
        split_q.push_back(s / 100 + 1);
        bus.data_in = 14'(v);
        bus.send    = 1'b1;
        tick();
        bus.send    = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            tick();
            if (bus.busy === 1'b0) quiet++;
            else quiet = 0;
        end
        check_eq("idle", bus.busy, 0);
        check_eq("sb_drain", exp_q.size(), 0);
        check_eq("split_drain", split_q.size(), 0);
    endtask

    // SPI slave model: answers each spi_start with spi_done after a delay, held done_len cycles.
    initial begin
        int         pend;
        int         phase;
        int         cnt;
        int         seen_flush;
        logic [7:0] cur_byte;
        pend       = 0;
        phase      = 0;
        cnt        = 0;
        seen_flush = 0;
        cur_byte   = 8'h00;
        bus.spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (flush_req != seen_flush) begin
                seen_flush   = flush_req;
                pend         = 0;
                phase        = 0;
                bus.spi_done = 1'b0;
            end else begin
                if (bus.spi_start === 1'b1) begin
                    n_start++;
                    check_eq("start_ssn", bus.ssn, 0);
                    check_eq("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check_eq("byte", bus.tx_data, exp_q.pop_front());
                    cur_byte = bus.tx_data;
                    pend++;
                end
                case (phase)
                    0: if (pend > 0) begin
                        pend--;
                        cnt   = done_delay;
                        phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            check_eq("tx_hold", bus.tx_data, cur_byte);
                            bus.spi_done = 1'b1;
                            cnt          = done_len;
                            phase        = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            if (pend > 0) begin
                                check_eq("held_once_ssn", bus.ssn, 0);
                                check_eq("held_once_busy", bus.busy, 1);
                            end
                            bus.spi_done = 1'b0;
                            phase        = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Frame monitor: SPLIT length is the busy-with-ssn-high stretch before ssn falls.
    initial begin
        int   split_cnt;
        logic prev_ssn;
        split_cnt = 0;
        prev_ssn  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.ssn === 1'b1) begin
                if (bus.busy === 1'b1) split_cnt++;
                if (prev_ssn === 1'b0) n_frames++;
            end else if (prev_ssn === 1'b1) begin
                check_eq("split_nonempty", split_q.size() != 0, 1);
                if (split_q.size() != 0) check_eq("split_len", split_cnt, split_q.pop_front());
                split_cnt = 0;
            end
            prev_ssn = bus.ssn;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int f0;
        n_cmp         = 0;
        n_err         = 0;
        n_start       = 0;
        n_frames      = 0;
        done_delay    = 2;
        done_len      = 1;
        flush_req     = 0;
        reset         = 1'b1;
        bus.data_in   = 14'd0;
        bus.send      = 1'b0;
        bus.spi_ready = 1'b1;

        repeat (3) tick();
        check_eq("rst_ssn", bus.ssn, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_start", bus.spi_start, 0);
        check_eq("rst_tx", bus.tx_data, 0);
        reset = 1'b0;
        tick();

        do_send(1234, 1'b0);
        wait_idle();

        do_send(0, 1'b0);
        wait_idle();

        do_send(9999, 1'b0);
        wait_idle();
        do_send(12000, 1'b0);
        wait_idle();

        f0 = n_frames;
        do_send(42, 1'b0);
        repeat (3) tick();
        do_send(77, 1'b0);
        repeat (2) tick();
        do_send(88, 1'b1);
        wait_idle();
        check_eq("pend_frames", n_frames - f0, 2);

        bus.spi_ready = 1'b0;
        done_len      = 5;
        base          = n_start;
        do_send(305, 1'b0);
        for (int i = 0; i < 200 && bus.ssn !== 1'b0; i++) tick();
        repeat (20) tick();
        check_eq("ready_low_nostart", n_start, base);
        check_eq("ready_low_ssn", bus.ssn, 0);
        bus.spi_ready = 1'b1;
        wait_idle();
        check_eq("held_starts", n_start, base + 2);
        done_len = 1;
        repeat (3) tick();

        base = n_start;
        do_send(4321, 1'b0);
        for (int i = 0; i < 500 && n_start < base + 2; i++) tick();
        check_eq("reach_wait_lo", n_start, base + 2);
        reset = 1'b1;
        #1;
        check_eq("abort_ssn", bus.ssn, 1);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_start", bus.spi_start, 0);
        check_eq("abort_tx", bus.tx_data, 0);
        flush_req++;
        exp_q.delete();
        split_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        base  = n_start;
        repeat (20) tick();
        check_eq("no_restart", n_start, base);
        check_eq("no_restart_busy", bus.busy, 0);

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        do_send(5, 1'b0);
        check_eq("accept_first", bus.busy, 1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
